// File: rtl/i2c_target_pkg.sv
// i2c_target_pkg: shared states, address and field widths for the I2C target (I2C_TARGET_READ_EN adds read states)
package i2c_target_pkg;
  localparam logic [6:0] WM8731_ADDR = 7'h1A;
  localparam logic ACK = 1'b0;
  localparam logic NACK = 1'b1;
  localparam int REG_W = 7;
  localparam int DATA_W = 9;
  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, BYTE_HI, ACK_HI, BYTE_LO, ACK_LO, IGNORE
`ifdef I2C_TARGET_READ_EN
    , RD_HI, RACK_HI, RD_LO, RACK_LO
`endif
  } state_t;
endpackage

// File: rtl/i2c_line_filter.sv
// i2c_line_filter: synchronizer, glitch filter and edge pulses for one open-drain line
module i2c_line_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);
  localparam int CW = $clog2(FILTER_LEN + 1);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  // level follows the synchronized pin only after FILTER_LEN consecutive differing samples
  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= 2'b11;
      level <= 1'b1;
      cnt <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[0], pin};
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync[1] == level) cnt <= '0;
      else if (cnt == CW'(FILTER_LEN - 1)) begin
        level <= sync[1];
        cnt <= '0;
        rise <= sync[1];
        fall <= ~sync[1];
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/i2c_target.sv
// i2c_target: WM8731-style I2C write target producing {reg, data} strobes; I2C_TARGET_READ_EN enables read-back
module i2c_target
  import i2c_target_pkg::*;
#(
  parameter logic [REG_W-1:0] TGT_ADDR = WM8731_ADDR,
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda_oe,
  output logic wr_valid,
  output logic [REG_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic busy,
  output logic addr_nack
);
  logic scl_lvl, scl_rise, scl_fall, sda_lvl, sda_rise, sda_fall;
  logic start, stop, last, addr_ok;
  logic [7:0] sh, hi, byte_nx;
  logic [3:0] cnt;
  state_t state;
`ifdef I2C_TARGET_READ_EN
  logic rd;
  logic [15:0] tx;
`endif
  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl (
    .clk(clk), .reset(reset), .pin(scl_in), .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
  );
  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda (
    .clk(clk), .reset(reset), .pin(sda_in), .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
  );
  assign start = sda_fall & scl_lvl;
  assign stop = sda_rise & scl_lvl;
  assign byte_nx = {sh[6:0], sda_lvl};
  assign last = cnt == 4'd7;
`ifdef I2C_TARGET_READ_EN
  assign addr_ok = byte_nx[7:1] == TGT_ADDR;
`else
  assign addr_ok = byte_nx == {TGT_ADDR, 1'b0};
`endif
  // protocol FSM: bus conditions take priority, bytes shift on SCL rise, ACK/read bits change after SCL fall
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      sh <= '0;
      hi <= '0;
      sda_oe <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      busy <= 1'b0;
      addr_nack <= 1'b0;
`ifdef I2C_TARGET_READ_EN
      rd <= 1'b0;
      tx <= '0;
`endif
    end else begin
      wr_valid <= 1'b0;
      addr_nack <= 1'b0;
      if (stop) begin
        state <= IDLE;
        busy <= 1'b0;
        sda_oe <= ~NACK;
      end else if (start) begin
        state <= ADDR;
        cnt <= '0;
        busy <= 1'b1;
        sda_oe <= ~NACK;
      end else begin
        case (state)
          ADDR, BYTE_HI, BYTE_LO: if (scl_rise) begin
            sh <= byte_nx;
            cnt <= last ? 4'd0 : cnt + 4'd1;
            if (last) begin
              if (state == ADDR) begin
                state <= addr_ok ? ADDR_ACK : IGNORE;
                addr_nack <= ~addr_ok;
`ifdef I2C_TARGET_READ_EN
                rd <= byte_nx[0];
                tx <= {wr_addr, wr_data};
`endif
              end else if (state == BYTE_HI) begin
                hi <= byte_nx;
                state <= ACK_HI;
              end else begin
                wr_addr <= hi[7:1];
                wr_data <= {hi[0], byte_nx};
                wr_valid <= 1'b1;
                state <= ACK_LO;
              end
            end
          end
          ADDR_ACK, ACK_HI, ACK_LO: if (scl_fall) begin
            if (!sda_oe) sda_oe <= ~ACK;
            else begin
              sda_oe <= ~NACK;
              state <= state == ACK_HI ? BYTE_LO : BYTE_HI;
`ifdef I2C_TARGET_READ_EN
              if (state == ADDR_ACK && rd) begin
                sda_oe <= ~tx[15];
                tx <= {tx[14:0], 1'b0};
                cnt <= 4'd1;
                state <= RD_HI;
              end
`endif
            end
          end
`ifdef I2C_TARGET_READ_EN
          RD_HI, RD_LO: if (scl_fall) begin
            if (cnt == 4'd8) begin
              sda_oe <= ~NACK;
              cnt <= '0;
              state <= state == RD_HI ? RACK_HI : RACK_LO;
            end else begin
              sda_oe <= ~tx[15];
              tx <= {tx[14:0], 1'b0};
              cnt <= cnt + 4'd1;
            end
          end
          RACK_HI: if (scl_rise) state <= sda_lvl == NACK ? IGNORE : RD_LO;
          RACK_LO: if (scl_rise) state <= IGNORE;
`endif
          default: ;
        endcase
      end
    end
  end
endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- I2C target (responder) that sits on the other end of the codec-configuration bus, opposite the existing I2C initiator.
- Receives WM8731-format control writes and presents each completed 16-bit word as a {reg addr, data} strobe.
- Used for on-board initiator loopback and as a synthesizable codec-register shadow.
- Never drives SCL (no clock stretching); drives SDA only low, via an open-drain enable.

Parameters:
- TGT_ADDR, 7'h1A, 7-bit target address (WM8731 with CSB=0; write byte 0x34).
- FILTER_LEN, 3, number of consecutive equal samples required before a filtered SCL/SDA level changes.

Ports:
- clk  in  1  system clock (12.288 MHz audio clock domain).
- reset  in  1  synchronous, active-high reset.
- scl_in  in  1  raw SCL pin level (asynchronous).
- sda_in  in  1  raw SDA pin level (asynchronous).
- sda_oe  out  1  1 = pull SDA low; top level drives Z when 0.
- wr_valid  out  1  one-cycle pulse when a full word is received.
- wr_addr  out  7  register address of the last word.
- wr_data  out  9  register data of the last word.
- busy  out  1  high from START until STOP.
- addr_nack  out  1  one-cycle pulse when an address byte does not match.

Behaviour:
- Reset (synchronous, active-high): all outputs 0, FSM in IDLE, filters preset to 1 (bus idle).
- Input conditioning:
  - 2-FF synchronizer, then glitch filter (FILTER_LEN), then edge detect.
  - Filtered edges are seen 2+FILTER_LEN clk after the pin edge.
- Bus conditions:
  - START = filtered SDA falls while SCL high.
  - STOP = SDA rises while SCL high.
  - Data is sampled on SCL rising edges only.
- FSM states: IDLE, ADDR, ADDR_ACK, BYTE_HI, ACK_HI, BYTE_LO, ACK_LO, IGNORE.
- State transitions:
  - START from any state -> ADDR; bit counter cleared; busy=1. This also covers repeated START.
  - ADDR: shift 8 bits MSB first.
    - On the 8th bit, if addr[7:1]==TGT_ADDR and R/W=0 -> ADDR_ACK.
    - Otherwise pulse addr_nack -> IGNORE.
  - ADDR_ACK / ACK_HI / ACK_LO:
    - sda_oe rises 1 clk after the SCL falling edge that ends the 8th bit.
    - sda_oe falls 1 clk after the next SCL falling edge (end of the 9th bit).
  - BYTE_HI: byte = {reg[6:0], data[8]} -> ACK_HI.
  - BYTE_LO: byte = data[7:0] -> ACK_LO.
    - wr_addr/wr_data update and wr_valid pulses 1 clk after the 8th bit is sampled.
  - After ACK_LO -> BYTE_HI: further byte pairs are independent new words (no auto-increment).
  - IGNORE: sda_oe=0; wait for START or STOP.
  - STOP from any state -> IDLE; busy=0; sda_oe=0.
- Boundary conditions:
  - STOP or START mid-word: partial word discarded, no wr_valid.
  - wr_addr/wr_data hold until the next valid word.
  - SDA change while SCL high in IDLE before any START: ignored.
  - reset mid-transfer: immediate IDLE, sda_oe=0 on the next clk, no pulse.

Optional Feature:
- I2C_TARGET_READ_EN defined:
  - Address with R/W=1 is ACKed, then the target returns 16 bits {wr_addr, wr_data} MSB first.
  - SDA changes 1 clk after each SCL fall; sda_oe = ~bit.
  - Initiator ACK after byte 1 continues to byte 2; NACK after either byte -> IGNORE.
  - Adds states RD_HI, RACK_HI, RD_LO, RACK_LO.
- Undefined: R/W=1 treated as an address mismatch (addr_nack, IGNORE).

Decomposition:
- Package i2c_target_pkg holds:
  - state enum;
  - WM8731_ADDR=7'h1A;
  - ACK=1'b0 and NACK=1'b1 constants;
  - word field widths (REG_W=7, DATA_W=9).
- Sub-module i2c_line_filter, instanced once per line: synchronizer, glitch filter, rise/fall outputs.

Test Plan:
- Write 0x34, 0x0C, 0x00, STOP -> 3 ACKs; wr_valid once with wr_addr=0x06, wr_data=0x000; busy low after STOP.
- Write 0x34, 0x01, 0xFF -> wr_addr=0x00, wr_data=0x1FF (data[8] taken from byte-1 LSB).
- Address byte 0x36 -> addr_nack pulse; SDA never pulled low; no wr_valid for following bytes.
- 0x34, 0x0C, then STOP -> no wr_valid; outputs unchanged. Then repeated START + 0x34, 0x12, 0x01 -> wr_addr=0x09, wr_data=0x001.
- reset asserted during the ACK_HI bit -> sda_oe=0 next clk, busy=0; the next full transaction is received normally.
- 1-clk glitches on SCL with FILTER_LEN=3 -> no extra bit shifted; word still decodes correctly.
